// File: rtl/l1_dcache_pkg.sv
// Shared types, width helpers and byte merge
// for the 2-way write-back L1 data cache.
package l1_dcache_pkg;

  localparam int unsigned DEF_SETS  = 128;
  localparam int unsigned DEF_WORDS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_UPDATE,
    S_FLUSH_SCAN,
    S_FLUSH_WB
  } state_e;

  function automatic int offset_bits(input int words);
    return $clog2(words) + 2;
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int sets, input int words);
    return 32 - index_bits(sets) - offset_bits(words);
  endfunction

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/l1_dcache_victim_sel.sv
// Victim way choice for a miss: fill invalid
// ways first, otherwise evict the LRU way.
module l1_dcache_victim_sel
  import l1_dcache_pkg::*;
(
  input  logic [1:0] valid,
  input  logic [1:0] dirty,
  input  logic       lru,
  output logic       victim,
  output logic       needs_wb
);

  always_comb begin
    victim = lru;
    if (!valid[0])
      victim = 1'b0;
    else if (!valid[1])
      victim = 1'b1;
    needs_wb = valid[victim] & dirty[victim];
  end

endmodule

// File: rtl/l1_dcache_wb.sv
// 2-way set-associative write-back, write-allocate
// L1 data cache with word-serial memory port.
module l1_dcache_wb
  import l1_dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS       = DEF_SETS,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  input  logic [3:0]  cpu_byte_enable,
  input  logic        cpu_write_enable,
  input  logic        cpu_read_enable,
  output logic [31:0] cpu_read_data,
  output logic        stall_cpu,
  input  logic        flush_req,
  output logic        flush_done,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_write_enable,
  output logic        mem_request,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready
);

  localparam int OB = offset_bits(WORDS_PER_LINE);
  localparam int IB = index_bits(NUM_SETS);
  localparam int TB = tag_bits(NUM_SETS, WORDS_PER_LINE);
  localparam int WB = $clog2(WORDS_PER_LINE);

  state_e        st;
  logic [WB-1:0] wcnt;
  logic [IB:0]   fcnt;
  logic          vway;

  logic [1:0][NUM_SETS-1:0] vld;
  logic [1:0][NUM_SETS-1:0] drt;
  logic [NUM_SETS-1:0]      lru;
  logic [TB-1:0] tg  [2][NUM_SETS];
  logic [31:0]   dat [2][NUM_SETS][WORDS_PER_LINE];
  logic [31:0]   rbuf [WORDS_PER_LINE];

  logic [IB-1:0] idx;
  logic [TB-1:0] tag_in;
  logic [WB-1:0] woff;
  logic          rd, wr, acc;
  logic [1:0]    hit_w;
  logic          hit, hway;
  logic          last_w, last_e;
  logic [IB-1:0] fset;
  logic          fway, fdirty;
  logic          vsel, vneed;
  logic          wb_way;
  logic [IB-1:0] wb_set;
  logic          unused;

  assign idx    = cpu_address[OB +: IB];
  assign tag_in = cpu_address[31 -: TB];
  assign woff   = cpu_address[2 +: WB];
  assign unused = ^cpu_address[1:0];

  // both enables high is treated as a load
  assign rd  = cpu_read_enable;
  assign wr  = cpu_write_enable & ~cpu_read_enable;
  assign acc = rd | wr;

  assign hit_w[0] = vld[0][idx] && (tg[0][idx] == tag_in);
  assign hit_w[1] = vld[1][idx] && (tg[1][idx] == tag_in);
  assign hit      = |hit_w;
  assign hway     = hit_w[1];

  assign last_w = &wcnt;
  assign last_e = &fcnt;
  assign fset   = fcnt[IB:1];
  assign fway   = fcnt[0];
  assign fdirty = vld[fway][fset] & drt[fway][fset];

  assign wb_way = (st == S_FLUSH_WB) ? fway : vway;
  assign wb_set = (st == S_FLUSH_WB) ? fset : idx;

  l1_dcache_victim_sel u_victim (
    .valid    ({vld[1][idx], vld[0][idx]}),
    .dirty    ({drt[1][idx], drt[0][idx]}),
    .lru      (lru[idx]),
    .victim   (vsel),
    .needs_wb (vneed)
  );

  always_comb begin
    cpu_read_data    = '0;
    stall_cpu        = 1'b0;
    flush_done       = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_byte_enable  = '0;
    mem_write_enable = 1'b0;
    mem_request      = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (acc && hit) begin
          if (rd)
            cpu_read_data = dat[hway][idx][woff];
        end else if (acc || flush_req) begin
          stall_cpu = 1'b1;
        end
      end
      S_WB, S_FLUSH_WB: begin
        stall_cpu        = 1'b1;
        mem_request      = 1'b1;
        mem_write_enable = 1'b1;
        mem_byte_enable  = 4'hF;
        mem_address      = {tg[wb_way][wb_set], wb_set, wcnt, 2'b00};
        mem_write_data   = dat[wb_way][wb_set][wcnt];
        flush_done       = (st == S_FLUSH_WB) &&
                           mem_ready && last_w && last_e;
      end
      S_FILL: begin
        stall_cpu   = 1'b1;
        mem_request = 1'b1;
        mem_address = {tag_in, idx, wcnt, 2'b00};
      end
      S_UPDATE: stall_cpu = 1'b1;
      S_FLUSH_SCAN: begin
        stall_cpu  = 1'b1;
        flush_done = !fdirty && last_e;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_IDLE;
      wcnt <= '0;
      fcnt <= '0;
      vway <= 1'b0;
      vld  <= '0;
      drt  <= '0;
      lru  <= '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (acc && hit) begin
            lru[idx] <= ~hway;
            if (wr)
              drt[hway][idx] <= 1'b1;
          end else if (acc) begin
            vway <= vsel;
            wcnt <= '0;
            st   <= vneed ? S_WB : S_FILL;
          end else if (flush_req) begin
            fcnt <= '0;
            st   <= S_FLUSH_SCAN;
          end
        end
        S_WB: begin
          if (mem_ready) begin
            wcnt <= wcnt + 1'b1;
            if (last_w)
              st <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            wcnt <= wcnt + 1'b1;
            if (last_w)
              st <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          vld[vway][idx] <= 1'b1;
          drt[vway][idx] <= 1'b0;
          lru[idx]       <= ~vway;
          st             <= S_IDLE;
        end
        S_FLUSH_SCAN: begin
          if (fdirty) begin
            wcnt <= '0;
            st   <= S_FLUSH_WB;
          end else if (last_e) begin
            st <= S_IDLE;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        S_FLUSH_WB: begin
          if (mem_ready) begin
            wcnt <= wcnt + 1'b1;
            if (last_w) begin
              drt[fway][fset] <= 1'b0;
              fcnt            <= fcnt + 1'b1;
              st <= last_e ? S_IDLE : S_FLUSH_SCAN;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  // line storage carries no reset; valid bits guard it
  always_ff @(posedge clk) begin
    if (st == S_IDLE && wr && hit)
      dat[hway][idx][woff] <= merge_bytes(
        dat[hway][idx][woff], cpu_write_data, cpu_byte_enable);
    if (st == S_FILL && mem_ready)
      rbuf[wcnt] <= mem_read_data;
    if (st == S_UPDATE) begin
      for (int w = 0; w < WORDS_PER_LINE; w++)
        dat[vway][idx][w] <= rbuf[w];
      tg[vway][idx] <= tag_in;
    end
  end

endmodule

// File: doc/l1_dcache_wb.md
# l1_dcache_wb

Parametrised, 2-way set-associative, write-back/write-allocate L1 data cache; next generation of the direct-mapped write-through data cache. Sits between the core's MEM stage and the word-serial memory port. Read and write hits complete with zero stall. Misses evict a dirty victim word-by-word, then refill the line. An explicit flush request writes back all dirty lines.

## Interface
- `NUM_SETS`, default 128: sets per way; power of two, ≥2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; power of two, ≥2.
- Derived: `OFFSET_BITS = log2(WORDS_PER_LINE)+2`, `INDEX_BITS = log2(NUM_SETS)`, `TAG_BITS = 32-INDEX_BITS-OFFSET_BITS`.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `cpu_address` in 32: byte address; word aligned.
- `cpu_write_data` in 32: store data.
- `cpu_byte_enable` in 4: store byte lanes.
- `cpu_write_enable` in 1: store request.
- `cpu_read_enable` in 1: load request.
- `cpu_read_data` out 32: load data; valid while read hit in IDLE, else 0.
- `stall_cpu` out 1: core must hold all cpu_* inputs stable while high.
- `flush_req` in 1: level; write back all dirty lines.
- `flush_done` out 1: one-cycle pulse at flush completion.
- `mem_address` out 32: word address.
- `mem_write_data` out 32: write-back data.
- `mem_byte_enable` out 4: always 4'hF during write-back, else 0.
- `mem_write_enable` out 1: high during write-back words.
- `mem_request` out 1: transfer request.
- `mem_read_data` in 32: refill data.
- `mem_ready` in 1: completes the current word when `mem_request` is high.

## Operation
- Per set and per way: valid, dirty, tag, and line data. One LRU bit per set names the least-recently-used way.
- Asynchronous reset clears all valid, dirty and LRU bits, the state register, and the counters. Data and tag arrays are not reset.
- All outputs are 0 during and after reset until an access arrives.
- Hit: `valid[w] && tag[w]==cpu_address[31:OFFSET_BITS-…]` matching on either way.
- If read and write enable are both high, the access is treated as a read.
- States:
  - **IDLE**
    - Read hit: `cpu_read_data` = selected word, combinationally; stall 0; LRU := other way.
    - Write hit: byte-masked update of the word; dirty:=1; LRU := other way; stall 0.
    - Miss: stall 1; choose victim (way0 if invalid, else way1 if invalid, else LRU way). Go to WB if victim valid&&dirty, else FILL.
    - `flush_req` with no CPU access: stall 1; go to FLUSH_SCAN with set/way counter at 0.
  - **WB**: `mem_request`=1, `mem_write_enable`=1, `mem_address`={victim tag, index, word_cnt, 2'b00}. Each `mem_ready` advances word_cnt. After the last word: FILL, word_cnt=0.
  - **FILL**: `mem_request`=1 with the read address of word_cnt; each `mem_ready` captures into the refill buffer. After the last word: UPDATE.
  - **UPDATE**: write the buffer, tag, valid=1, dirty=0 into the victim way; LRU := other way; stall 1; go to IDLE. The access is re-evaluated there as a hit. A store then merges and sets dirty.
  - **FLUSH_SCAN**: if the current {set,way} is valid&&dirty, go to FLUSH_WB; else advance. After the last entry, pulse `flush_done` for 1 cycle and go to IDLE.
  - **FLUSH_WB**: same as WB for that entry. Then clear dirty (valid kept), advance, and return to FLUSH_SCAN.
- Handshake:
  - `mem_address` and `mem_write_data` are stable while `mem_request` is high and `mem_ready` is low.
  - `mem_ready` is ignored when `mem_request` is low.
- `flush_req` is not sampled outside IDLE. A CPU access in IDLE takes priority over a flush.
- Reset mid-operation: return to IDLE immediately and drop all dirty data. Software flushes before reset if coherence is required.

## Timing
- Read and write hit: 0 stall cycles.
- Clean miss with `mem_ready` held high: stall for 1 (IDLE) + `WORDS_PER_LINE` (FILL) + 1 (UPDATE) cycles. The access completes in the following IDLE cycle. Default: 6 stalled cycles.
- Dirty miss: add `WORDS_PER_LINE` cycles. Default: 10.
- Each memory wait cycle adds one cycle of stall.
- Flush: 1 cycle per clean entry, plus `WORDS_PER_LINE`+1 cycles per dirty entry, plus 1 cycle for the IDLE exit.

## Structure
- Package `l1_dcache_pkg`: state enum (IDLE, WB, FILL, UPDATE, FLUSH_SCAN, FLUSH_WB), the `clog2`-derived width constants, and a byte-merge function.
- Sub-module `l1_dcache_victim_sel` (combinational): inputs are valid[1:0], dirty[1:0], and the LRU bit. Outputs are the victim way and a needs_wb flag.

## Test plan
- Cold read of 0x0000_0100 with memory words 0x11,0x22,0x33,0x44 and `mem_ready` high → 6 stall cycles, four reads at 0x100/104/108/10C, `cpu_read_data`=0x11. A re-read of 0x104 returns 0x22 with 0 stall.
- Store 0xDEADBEEF with byte_enable 4'b0011 to 0x108 after fill → no stall and no memory traffic. Reading 0x108 returns 0x0000BEEF merged onto 0x33 = 0x0000BEEF | (0x33 & 0xFFFF0000) = 0x0000BEEF.
- Fill the same set from 0x0100 (dirty) and 0x0900, touch 0x0900, then read 0x1100 → 0x0100 is evicted. Four writes at 0x100–0x10C carry the merged data, followed by a refill of 0x1100; 10 stall cycles.
- `mem_ready` low for 3 cycles on every word during a clean miss → `mem_address` is stable throughout; stall is 6+12 cycles.
- `flush_req` with two dirty lines → eight write-back words, a single `flush_done` pulse, and dirty bits cleared. A second flush produces no memory traffic.
- `rst_n` asserted during WB word 2 → outputs go to 0 immediately. After release, a read of 0x0100 misses.
